// File: rtl/sel4_dispatch_sched_if.sv
// Bundle of request, selector and credit signals shared between producer logic and the
// dispatch scheduler.
interface sel4_dispatch_sched_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]              i_req_valid;
  logic [4*DATA_WIDTH-1:0] i_req_data;
  logic [15:0]             i_req_dest;
  logic [3:0]              o_req_ready;
  logic                    o_drive;
  logic [DATA_WIDTH+3:0]   o_sel_data;
  logic                    i_free;
  logic [3:0]              i_done;
  logic                    o_busy;
  logic                    o_err;
  logic                    i_err_clr;

  // Producer / environment side
  modport master (
    output i_req_valid, i_req_data, i_req_dest, i_free, i_done, i_err_clr,
    input  o_req_ready, o_drive, o_sel_data, o_busy, o_err
  );

  // Scheduler side
  modport slave (
    input  i_req_valid, i_req_data, i_req_dest, i_free, i_done, i_err_clr,
    output o_req_ready, o_drive, o_sel_data, o_busy, o_err
  );
endinterface

// File: rtl/sel4_dispatch_sched.sv
// Round-robin, credit-gated scheduler that feeds one 4-way selector stage one token at a
// time and sequences the drive/free handshake.
module sel4_dispatch_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CREDIT_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  rstn,
  sel4_dispatch_sched_if.slave bus
);
  localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [CW-1:0]         credit_q [4];
  logic [CW-1:0]         credit_d [4];
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH+3:0] sel_q, sel_d;
  logic                  err_q, err_d;

  logic [3:0] elig, zero_req, ready;
  logic       grant_vld, zero_vld, err_wait, err_sat;
  logic [1:0] grant_idx, zero_idx;

  // Per-requester eligibility: valid, nonzero mask, credit on every addressed destination
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      elig[r]     = bus.i_req_valid[r] && (bus.i_req_dest[r*4 +: 4] != 4'b0000);
      zero_req[r] = bus.i_req_valid[r] && (bus.i_req_dest[r*4 +: 4] == 4'b0000);
      for (int d = 0; d < 4; d++) begin
        if (bus.i_req_dest[r*4 + d] && (credit_q[d] == '0)) elig[r] = 1'b0;
      end
    end
  end

  // Scan from rr_ptr upward; iterating backwards lets the closest hit overwrite the rest
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    zero_vld  = 1'b0;
    zero_idx  = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[rr_ptr_q + k[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_ptr_q + k[1:0];
      end
      if (zero_req[rr_ptr_q + k[1:0]]) begin
        zero_vld = 1'b1;
        zero_idx = rr_ptr_q + k[1:0];
      end
    end
  end

  // Next-state: handshake sequencing, selector word latch, wait timer
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    wait_cnt_d = wait_cnt_q;
    ready      = 4'b0000;
    err_wait   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ready[grant_idx] = 1'b1;
          gnt_d   = grant_idx;
          sel_d   = {bus.i_req_dest[{grant_idx, 2'b00} +: 4],
                     bus.i_req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH]};
          state_d = ISSUE;
        end else if (zero_vld) begin
          // Empty mask: accept and drop, no token launched
          ready[zero_idx] = 1'b1;
          rr_ptr_d        = zero_idx + 2'd1;
        end
      end
      ISSUE: begin
        rr_ptr_d = gnt_q + 2'd1;
        state_d  = bus.i_free ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.i_free) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == 8'(TIMEOUT - 1)) err_wait = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit bookkeeping: ISSUE consumes the latched mask, i_done returns, collisions cancel
  always_comb begin
    err_sat = 1'b0;
    for (int d = 0; d < 4; d++) begin
      credit_d[d] = credit_q[d];
      if (bus.i_done[d] && !((state_q == ISSUE) && sel_q[DATA_WIDTH + d])) begin
        if (credit_q[d] == CW'(CREDIT_MAX)) err_sat = 1'b1;
        else credit_d[d] = credit_q[d] + CW'(1);
      end else if (!bus.i_done[d] && (state_q == ISSUE) && sel_q[DATA_WIDTH + d]) begin
        credit_d[d] = credit_q[d] - CW'(1);
      end
    end
    // A set condition beats a simultaneous clear
    if (err_wait || err_sat) err_d = 1'b1;
    else if (bus.i_err_clr)  err_d = 1'b0;
    else                     err_d = err_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      wait_cnt_q <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      for (int d = 0; d < 4; d++) credit_q[d] <= CW'(CREDIT_MAX);
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      wait_cnt_q <= wait_cnt_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      for (int d = 0; d < 4; d++) credit_q[d] <= credit_d[d];
    end
  end

  // Output decodes; ready is held low while reset is asserted
  always_comb begin
    bus.o_req_ready = rstn ? ready : 4'b0000;
    bus.o_drive     = (state_q == ISSUE);
    bus.o_busy      = (state_q != IDLE);
    bus.o_sel_data  = sel_q;
    bus.o_err       = err_q;
  end
endmodule

// File: tb/tb_sel4_dispatch_sched.sv
// Self-checking bench for sel4_dispatch_sched: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_sel4_dispatch_sched;
  localparam int DW = 32;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  sel4_dispatch_sched_if #(.DATA_WIDTH(DW)) bus ();

  sel4_dispatch_sched #(.DATA_WIDTH(DW), .CREDIT_MAX(4), .TIMEOUT(255)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int             m_credit [4];
  int             m_rr;
  int             m_phase;   // 0 idle, 1 issuing, 2 waiting for free
  int             m_gnt;
  logic [DW+3:0]  m_sel;
  int             m_wait;
  bit             m_err;

  task automatic clear_inputs();
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_dest  = '0;
    bus.i_free      = 1'b0;
    bus.i_done      = '0;
    bus.i_err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    bus.i_req_valid = 4'b0001;
    bus.i_req_dest  = 16'h0001;
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0000 || bus.o_drive !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_err !== 1'b0 || bus.o_sel_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b drive=%b busy=%b err=%b sel=%h, required all zero",
               bus.o_req_ready, bus.o_drive, bus.o_busy, bus.o_err, bus.o_sel_data);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dut.credit_q[d] !== 3'd4) begin
        failures++;
        $display("FAIL reset_credit[%0d]: got %0d, required 4", d, dut.credit_q[d]);
      end
    end
    clear_inputs();
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW+3:0] exp_sel;
    do_reset();
    exp_sel = {4'b0100, 32'h0000_00A5};
    bus.i_req_valid = 4'b0010;
    bus.i_req_dest  = 16'h0040;
    bus.i_req_data  = {32'h0, 32'h0, 32'h0000_00A5, 32'h0};
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0010 || bus.o_drive !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready_T: ready=%b drive=%b, required 0010/0", bus.o_req_ready,
               bus.o_drive);
    end
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
    checks++;
    if (bus.o_drive !== 1'b1 || bus.o_req_ready !== 4'b0000 || bus.o_sel_data !== exp_sel) begin
      failures++;
      $display("FAIL basic_drive_T1: drive=%b ready=%b sel=%h, required 1/0000/%h",
               bus.o_drive, bus.o_req_ready, bus.o_sel_data, exp_sel);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_drive !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_sel_data !== exp_sel) begin
      failures++;
      $display("FAIL basic_wait_T2: drive=%b busy=%b sel=%h, required 0/1/%h", bus.o_drive,
               bus.o_busy, bus.o_sel_data, exp_sel);
    end
    @(negedge clk);
    bus.i_free = 1'b1;
    @(negedge clk);
    bus.i_free = 1'b0;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || dut.credit_q[2] !== 3'd3) begin
      failures++;
      $display("FAIL basic_idle_T4: busy=%b credit2=%0d, required 0/3", bus.o_busy,
               dut.credit_q[2]);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus.i_req_valid = 4'b1111;
    bus.i_req_dest  = 16'h8421;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.o_req_ready !== 4'(1 << order[i])) begin
        failures++;
        $display("FAIL rr_grant[%0d]: ready=%b, required %b", i, bus.o_req_ready,
                 4'(1 << order[i]));
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.o_drive !== 1'b1) begin
        failures++;
        $display("FAIL rr_drive[%0d]: drive=%b, required 1", i, bus.o_drive);
      end
      @(negedge clk);
      @(negedge clk);
      bus.i_free = 1'b1;
      bus.i_done = 4'(1 << order[i]);
      @(negedge clk);
      bus.i_free = 1'b0;
      bus.i_done = '0;
    end
    clear_inputs();
  endtask

  task automatic test_credit_stall();
    do_reset();
    bus.i_req_valid = 4'b0001;
    bus.i_req_dest  = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.o_req_ready !== 4'b0001) begin
        failures++;
        $display("FAIL stall_grant[%0d]: ready=%b, required 0001", i, bus.o_req_ready);
      end
      @(negedge clk);
      bus.i_free = 1'b1;
      @(negedge clk);
      bus.i_free = 1'b0;
    end
    repeat (3) begin
      #1;
      checks++;
      if (bus.o_req_ready !== 4'b0000 || bus.o_busy !== 1'b0) begin
        failures++;
        $display("FAIL stall_blocked: ready=%b busy=%b, required 0000/0", bus.o_req_ready,
                 bus.o_busy);
      end
      @(negedge clk);
    end
    bus.i_done = 4'b0001;
    @(negedge clk);
    bus.i_done = '0;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL stall_release: ready=%b, required 0001", bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_req_valid = '0;
    bus.i_free = 1'b1;
    @(negedge clk);
    bus.i_free = 1'b0;
  endtask

  task automatic test_multicast();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    bus.i_req_valid = 4'b0100;
    bus.i_req_dest  = 16'h0B00;
    bus.i_req_data  = {32'h0, d, 32'h0, 32'h0};
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL mc_grant: ready=%b, required 0100", bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_req_valid = '0;
    bus.i_done = 4'b0010;
    #1;
    checks++;
    if (bus.o_drive !== 1'b1 || bus.o_sel_data !== {4'b1011, d}) begin
      failures++;
      $display("FAIL mc_drive: drive=%b sel=%h, required 1/%h", bus.o_drive, bus.o_sel_data,
               {4'b1011, d});
    end
    @(negedge clk);
    bus.i_done = '0;
    #1;
    checks++;
    if (dut.credit_q[0] !== 3'd3 || dut.credit_q[1] !== 3'd4 || dut.credit_q[2] !== 3'd4 ||
        dut.credit_q[3] !== 3'd3 || bus.o_err !== 1'b0) begin
      failures++;
      $display("FAIL mc_credits: c=%0d,%0d,%0d,%0d err=%b, required 3,4,4,3 err=0",
               dut.credit_q[0], dut.credit_q[1], dut.credit_q[2], dut.credit_q[3], bus.o_err);
    end
    bus.i_free = 1'b1;
    @(negedge clk);
    bus.i_free = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.i_req_valid = 4'b1000;
    bus.i_req_dest  = 16'h8000;
    @(negedge clk);
    bus.i_req_valid = '0;
    repeat (255) @(negedge clk);
    #1;
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%b busy=%b after 254 waits, required 0/1", bus.o_err,
               bus.o_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set: err=%b busy=%b after 255 waits, required 1/1", bus.o_err,
               bus.o_busy);
    end
    bus.i_free = 1'b1;
    @(negedge clk);
    bus.i_free = 1'b0;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_free: busy=%b err=%b, required 0/1", bus.o_busy, bus.o_err);
    end
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    #1;
    checks++;
    if (bus.o_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clr: err=%b, required 0", bus.o_err);
    end
  endtask

  task automatic test_error_paths();
    do_reset();
    bus.i_done = 4'b0100;
    @(negedge clk);
    bus.i_done = '0;
    #1;
    checks++;
    if (dut.credit_q[2] !== 3'd4 || bus.o_err !== 1'b1) begin
      failures++;
      $display("FAIL sat_done: credit2=%0d err=%b, required 4/1", dut.credit_q[2], bus.o_err);
    end
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    bus.i_req_valid = 4'b0001;
    bus.i_req_dest  = 16'h0000;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0001 || bus.o_err !== 1'b0) begin
      failures++;
      $display("FAIL zero_ready: ready=%b err=%b, required 0001/0", bus.o_req_ready, bus.o_err);
    end
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
    checks++;
    if (bus.o_drive !== 1'b0 || bus.o_busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
      failures++;
      $display("FAIL zero_drop: drive=%b busy=%b rr=%0d, required 0/0/1", bus.o_drive,
               bus.o_busy, dut.rr_ptr_q);
    end
  endtask

  // Model: which requester the scheduler should accept given current inputs
  task automatic model_eval(output logic [3:0] rdy);
    int g;
    int z;
    g = -1;
    z = -1;
    rdy = '0;
    if (m_phase == 0) begin
      for (int k = 3; k >= 0; k--) begin
        int r;
        bit ok;
        r = (m_rr + k) % 4;
        ok = bus.i_req_valid[r] && (bus.i_req_dest[r*4 +: 4] != 0);
        for (int d = 0; d < 4; d++) if (bus.i_req_dest[r*4 + d] && m_credit[d] == 0) ok = 0;
        if (ok) g = r;
        if (bus.i_req_valid[r] && bus.i_req_dest[r*4 +: 4] == 0) z = r;
      end
      if (g >= 0) rdy[g] = 1'b1;
      else if (z >= 0) rdy[z] = 1'b1;
    end
  endtask

  task automatic model_commit(input logic [3:0] rdy);
    bit set_err;
    int r;
    set_err = 0;
    for (int d = 0; d < 4; d++) begin
      bit used;
      used = (m_phase == 1) && m_sel[DW + d];
      if (bus.i_done[d] && !used) begin
        if (m_credit[d] == 4) set_err = 1;
        else m_credit[d]++;
      end else if (used && !bus.i_done[d]) begin
        m_credit[d]--;
      end
    end
    r = 0;
    for (int k = 0; k < 4; k++) if (rdy[k]) r = k;
    if (m_phase == 0) begin
      if (rdy != 0 && bus.i_req_dest[r*4 +: 4] != 0) begin
        m_gnt = r;
        m_sel = {bus.i_req_dest[r*4 +: 4], bus.i_req_data[r*DW +: DW]};
        m_phase = 1;
      end else if (rdy != 0) begin
        m_rr = (r + 1) % 4;
      end
    end else if (m_phase == 1) begin
      m_rr = (m_gnt + 1) % 4;
      m_phase = bus.i_free ? 0 : 2;
    end else begin
      if (bus.i_free) begin
        m_phase = 0;
        m_wait = 0;
      end else if (m_wait < 255) begin
        m_wait++;
        if (m_wait == 255) set_err = 1;
      end
    end
    if (set_err) m_err = 1;
    else if (bus.i_err_clr) m_err = 0;
  endtask

  task automatic test_random();
    bit          pend [4];
    logic [3:0]  exp_rdy;
    do_reset();
    for (int d = 0; d < 4; d++) m_credit[d] = 4;
    m_rr = 0;
    m_phase = 0;
    m_gnt = 0;
    m_sel = '0;
    m_wait = 0;
    m_err = 0;
    for (int r = 0; r < 4; r++) pend[r] = 0;
    exp_rdy = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int r = 0; r < 4; r++) begin
        if (exp_rdy[r]) pend[r] = 0;
        if (!pend[r] && ($urandom % 3 == 0)) begin
          pend[r] = 1;
          bus.i_req_dest[r*4 +: 4] = 4'($urandom_range(0, 15));
          bus.i_req_data[r*DW +: DW] = $urandom;
        end
        bus.i_req_valid[r] = pend[r];
      end
      for (int d = 0; d < 4; d++) bus.i_done[d] = ($urandom % 5 == 0);
      bus.i_err_clr = ($urandom % 8 == 0);
      bus.i_free = (m_phase != 0) ? ($urandom % 5 < 2) : ($urandom % 20 == 0);
      #1;
      model_eval(exp_rdy);
      checks++;
      if (bus.o_req_ready !== exp_rdy || bus.o_drive !== (m_phase == 1) ||
          bus.o_busy !== (m_phase != 0) || bus.o_err !== m_err ||
          bus.o_sel_data !== m_sel) begin
        failures++;
        $display("FAIL random_cyc%0d: ready=%b drive=%b busy=%b err=%b sel=%h, required %b/%b/%b/%b/%h",
                 cyc, bus.o_req_ready, bus.o_drive, bus.o_busy, bus.o_err, bus.o_sel_data,
                 exp_rdy, (m_phase == 1), (m_phase != 0), m_err, m_sel);
      end
      @(posedge clk);
      model_commit(exp_rdy);
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_credit_stall();
    test_multicast();
    test_timeout();
    test_error_paths();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sel4_dispatch_sched.md
# sel4_dispatch_sched

Clocked scheduler that shares one 4-way cSelector stage between four requesters. It round-robin arbitrates requests carrying a payload and a destination mask, and gates each request on per-destination credits. It builds the selector input word {valid_4, data} and sequences the drive/free handshake one token at a time. It sits between the synchronous producer logic and the asynchronous selector pipeline; the `o_drive` and `i_free` event lines are synchronized to `clk` outside this block.

## Interface
- `DATA_WIDTH`, 32: payload width per requester.
- `CREDIT_MAX`, 4: maximum outstanding tokens per destination. Counter width `CW = $clog2(CREDIT_MAX+1)`.
- `TIMEOUT`, 255: WAIT cycles without `i_free` before `o_err` sets. Counter width 8, so `TIMEOUT` must be ≤ 255.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rstn`  in  1  reset: synchronous, active-low.
- `i_req_valid`  in  4  per-requester request level; held until accepted.
- `i_req_data`  in  4*DATA_WIDTH  payload; requester r at `[r*DATA_WIDTH +: DATA_WIDTH]`.
- `i_req_dest`  in  16  one-hot/multicast destination mask; requester r at `[r*4 +: 4]`.
- `o_req_ready`  out  4  one-cycle accept pulse; at most one bit set.
- `o_drive`  out  1  one-cycle pulse that launches a token into the selector.
- `o_sel_data`  out  DATA_WIDTH+4  selector input word. `[DATA_WIDTH+3:DATA_WIDTH]` = valid mask, low bits = payload.
- `i_free`  in  1  one-cycle pulse meaning the selector has taken the token (its freeNext OR).
- `i_done`  in  4  one-cycle credit-return pulse per destination.
- `o_busy`  out  1  high in ISSUE or WAIT.
- `o_err`  out  1  sticky error flag.
- `i_err_clr`  in  1  clears `o_err`.

## Operation
- State machine: IDLE, ISSUE, WAIT.
- Eligibility: requester r is eligible iff `i_req_valid[r]` is high, its mask is nonzero, and `credit[d] > 0` for every bit d set in its mask.
- **IDLE:**
  - Grant g = first eligible requester scanning from `rr_ptr` upward, mod 4.
  - In the same cycle: `o_req_ready[g]=1`; `o_sel_data` latches {mask, data} of g at the clock edge; next state ISSUE.
  - Zero-mask request: if no eligible requester exists and the request at the scan position has `valid` high with mask 0, it is accepted (ready pulse) and dropped. There is no drive, `rr_ptr` advances past it, and the state stays IDLE.
- **ISSUE:**
  - `o_drive=1` for exactly this cycle.
  - `credit[d]` decrements for each mask bit d.
  - `rr_ptr <= g+1` mod 4.
  - Next state: WAIT, or IDLE if `i_free` is high this cycle.
- **WAIT:**
  - The wait counter increments each cycle; it saturates.
  - `i_free` high: go to IDLE and clear the counter.
  - Counter reaches `TIMEOUT`: `o_err <= 1`. Stay in WAIT; the token is never abandoned.
- `i_free` in IDLE is ignored.
- **Credits:**
  - `i_done[d]` increments `credit[d]`.
  - If an ISSUE decrement and an `i_done` hit the same destination in the same cycle, the credit is unchanged.
  - `i_done[d]` while `credit[d]==CREDIT_MAX` is ignored (saturate) and sets `o_err`.
- `o_sel_data` holds its value from the latch until the next grant; it is stable through ISSUE and WAIT.
- `i_err_clr` clears `o_err`. A set condition in the same cycle wins.

## Timing
- Reset (`rstn` low at a clock edge) applies:
  - state IDLE, `rr_ptr`=0, all credits = `CREDIT_MAX`, wait counter 0;
  - `o_req_ready`=0, `o_drive`=0, `o_sel_data`=0, `o_busy`=0, `o_err`=0.
- Reset mid-WAIT discards the token tracking; the selector must be reset together with this block.
- Latency:
  - Request seen in IDLE at cycle T: ready at T, `o_drive` at T+1.
  - Earliest next grant is the cycle after `i_free` returns to IDLE.
  - Back-to-back minimum period is 3 cycles, or 2 cycles if `i_free` arrives during ISSUE.
- `o_req_ready` and `o_drive` are registered-state decodes; they are never high in the same cycle.
- Requesters must hold data, dest and valid stable until their ready pulse.

## Test plan
- **Reset values:** reset, then requester 1 valid with mask 4'b0100 and data 0xA5 -> ready[1] at T, `o_drive` at T+1, `o_sel_data` = {4'b0100, 0xA5}; `i_free` at T+3 -> IDLE at T+4, `credit[2]`=3.
- **Round-robin:** all four requesters valid continuously with distinct single destinations, `i_free` 2 cycles after each drive -> grant order 0,1,2,3,0; no requester is skipped.
- **Credit stall:** five requests to dest 0 with no `i_done` -> four drives, then the fifth stalls in IDLE. A single `i_done[0]` -> fifth is granted the next cycle.
- **Multicast and collision:** mask 4'b1011 -> credits 0, 1 and 3 each drop by 1. `i_done[1]` in the ISSUE cycle -> `credit[1]` unchanged.
- **Timeout:** drive issued, `i_free` withheld -> `o_err`=1 after 255 WAIT cycles, `o_busy` stays 1. A later `i_free` -> IDLE. `i_err_clr` -> `o_err`=0.
- **Error paths:** `i_done[2]` with `credit[2]`=4 -> credit stays 4, `o_err`=1. Zero-mask request -> ready pulse, no `o_drive`, `rr_ptr` advances.
